// File: rtl/spi_key_sequencer_if.sv
// Byte-level handshake between the key sequencer and an SPI master.
// The sequencer uses the master modport; the SPI master (or a model of it) uses slave.
interface spi_key_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_data_out;

  modport master (
    output spi_start,
    output spi_data_in,
    input  spi_busy,
    input  spi_done,
    input  spi_data_out
  );

  modport slave (
    input  spi_start,
    input  spi_data_in,
    output spi_busy,
    output spi_done,
    output spi_data_out
  );
endinterface

// File: rtl/spi_key_sequencer.sv
// Sequences an SPI master through NUM_BYTES back-to-back byte transfers to
// send a latched key MSB byte first, assembling the returned bytes into rx_key.
// Enforces an idle gap between bytes, a per-byte timeout and a clean abort.
module spi_key_sequencer #(
  parameter int NUM_BYTES      = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,      // asynchronous, active-low
  input  logic                   go,
  input  logic                   abort,
  input  logic [8*NUM_BYTES-1:0] key_in,
  output logic                   busy,
  output logic                   key_done,
  output logic                   error,
  output logic [8*NUM_BYTES-1:0] rx_key,
  spi_key_sequencer_if.master    spi
);

  localparam int KEY_W = 8 * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [KEY_W-1:0]   rx_key_q, rx_key_d;
  logic               error_q, error_d;
  logic [7:0]         data_in_q, data_in_d;

  logic abort_hit;
  logic last_byte;
  logic tmo_hit;
  logic gap_end;

  // Byte i of a key word; byte 0 is the most significant byte.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] word,
                                          input logic [IDX_W-1:0] i);
    key_byte = 8'h00;
    for (int n = 0; n < NUM_BYTES; n++) begin
      if (i == IDX_W'(n)) key_byte = word[KEY_W-8-8*n +: 8];
    end
  endfunction

  // Returns word with byte i replaced by val, same byte order as key_byte.
  function automatic logic [KEY_W-1:0] put_byte(input logic [KEY_W-1:0] word,
                                                input logic [IDX_W-1:0] i,
                                                input logic [7:0]       val);
    put_byte = word;
    for (int n = 0; n < NUM_BYTES; n++) begin
      if (i == IDX_W'(n)) put_byte[KEY_W-8-8*n +: 8] = val;
    end
  endfunction

  assign abort_hit = abort && (state_q == S_START || state_q == S_WAIT || state_q == S_GAP);
  assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));
  assign tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign gap_end   = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

  // State register; reset forces IDLE at any point in a transfer.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: flops are only ever assigned with <= so every register samples the
    // pre-edge value of every other register, independent of block order.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort outranks spi_done, which outranks the timeout.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_d and no
    // latch is inferred; the same pattern is used in every comb block here.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: begin
        if (abort_hit)         state_d = S_DONE;
        else if (!spi.spi_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort_hit) begin
          state_d = S_DONE;
        end else if (spi.spi_done) begin
          if (last_byte)            state_d = S_DONE;
          else if (GAP_CYCLES == 0) state_d = S_START;
          else                      state_d = S_GAP;
        end else if (tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (abort_hit)    state_d = S_DONE;
        else if (gap_end) state_d = S_START;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and datapath registers.
  always_comb begin
    busy            = (state_q != S_IDLE);
    key_done        = (state_q == S_DONE);
    spi.spi_start   = (state_q == S_START) && !spi.spi_busy;
    spi.spi_data_in = data_in_q;
    error           = error_q;
    rx_key          = rx_key_q;
  end

  // Datapath next values: key latch, byte index, counters, rx assembly, error.
  always_comb begin
    key_d     = key_q;
    rx_key_d  = rx_key_q;
    error_d   = error_q;
    idx_d     = idx_q;
    data_in_d = data_in_q;
    gap_cnt_d = gap_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          key_d     = key_in;
          rx_key_d  = '0;
          error_d   = 1'b0;
          idx_d     = '0;
          data_in_d = key_byte(key_in, '0);
        end
      end
      S_START: begin
        if (abort_hit)          error_d   = 1'b1;
        else if (!spi.spi_busy) tmo_cnt_d = '0;
      end
      S_WAIT: begin
        if (abort_hit) begin
          error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (spi.spi_done) begin
            rx_key_d = put_byte(rx_key_q, idx_q, spi.spi_data_out);
            if (!last_byte) begin
              idx_d     = idx_q + IDX_W'(1);
              data_in_d = key_byte(key_q, idx_q + IDX_W'(1));
              gap_cnt_d = '0;
            end
          end else if (tmo_hit) begin
            error_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort_hit) error_d   = 1'b1;
        else           gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; everything, including the wide key and rx words, resets to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the 128-bit key latch is reset too even though it is reloaded on
      // every go; it keeps the block free of X after reset at a small cost.
      key_q     <= '0;
      rx_key_q  <= '0;
      error_q   <= 1'b0;
      idx_q     <= '0;
      data_in_q <= '0;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      key_q     <= key_d;
      rx_key_q  <= rx_key_d;
      error_q   <= error_d;
      idx_q     <= idx_d;
      data_in_q <= data_in_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: doc/spi_key_sequencer.md
# spi_key_sequencer

Controller that sequences the SPI master to transfer a full 128-bit AES key as 16 back-to-back byte transactions. It sits between the AES key source and the SPI master. It drives the master's `start` and `data_in`, waits for each byte's completion, and assembles the bytes returned on MISO into a 128-bit receive word. It also guarantees inter-byte idle gaps, a per-byte timeout, and a clean abort.

## Interface
- `NUM_BYTES`, 16: bytes per key transfer; the key width is 8*NUM_BYTES.
- `GAP_CYCLES`, 2: idle clk cycles between the end of one byte and the next start, so CS deasserts between bytes.
- `TIMEOUT_CYCLES`, 1024: maximum clk cycles spent waiting for `spi_done` on one byte.

Ports:
- `clk`: in, 1. System clock; all logic is rising-edge.
- `reset`: in, 1. Reset is asynchronous and active-low.
- `go`: in, 1. Request a key transfer; sampled only in IDLE.
- `abort`: in, 1. Cancel the transfer in progress.
- `key_in`: in, 8*NUM_BYTES. Key to send; latched when `go` is accepted.
- `busy`: out, 1. High while a transfer is in progress.
- `key_done`: out, 1. Single-cycle pulse at the end of a transfer, whether successful or in error.
- `error`: out, 1. Sticky flag set on timeout or abort; cleared when the next `go` is accepted.
- `rx_key`: out, 8*NUM_BYTES. Bytes received from the master's `data_out`.
- `spi_start`: out, 1. Drives the master's `start`.
- `spi_data_in`: out, 8. Drives the master's `data_in`.
- `spi_busy`: in, 1. The master's busy output.
- `spi_done`: in, 1. The master's done output; a single-cycle pulse per byte.
- `spi_data_out`: in, 8. The master's received byte; valid in the cycle `spi_done` is high.

## Operation
States are IDLE, START, WAIT, GAP and DONE. Internal state:
- byte index `idx`, 0..NUM_BYTES-1
- gap counter
- timeout counter
- latched key register

Byte order:
- Byte i is `key_in[8*NUM_BYTES-1-8*i -: 8]`, so byte 0 is the MSB byte.
- The received byte i is written to the same slice of `rx_key`.

State behaviour:
- IDLE: `busy`=0. When `go`=1:
  - latch `key_in`
  - clear `rx_key` and `error`
  - set `idx`=0 and `spi_data_in`=byte 0
  - go to START
- START: `spi_start` = !`spi_busy` (combinational on the registered state).
  - The first cycle with `spi_busy`=0 asserts `spi_start` for exactly that cycle, clears the timeout counter, and goes to WAIT.
  - While `spi_busy`=1, stay in START with `spi_start`=0.
- WAIT: the timeout counter increments each cycle.
  - On `spi_done`=1: capture `spi_data_out` into `rx_key` byte `idx`. If `idx`=NUM_BYTES-1 go to DONE; otherwise `idx`+1, load the next byte onto `spi_data_in`, and go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without `spi_done`: set `error`=1 and go to DONE.
  - If `spi_done` and timeout coincide, `spi_done` wins.
- GAP: count GAP_CYCLES cycles, then go to START. If GAP_CYCLES=0, go straight to START.
- DONE: `key_done`=1 for one cycle, `busy` is still high, then go to IDLE.
- `abort`=1 in START, WAIT or GAP: set `error`=1 and go to DONE next cycle.
  - In DONE or IDLE, `abort` is ignored.
  - `abort` has priority over `spi_done` and timeout in the same cycle; the byte is not captured.
- `spi_data_in` holds stable from the START entry until the next byte is loaded.
- `go` outside IDLE is ignored. A `go` held high in IDLE after DONE starts a new transfer.
- Asynchronous reset, including mid-transfer, forces IDLE with:
  - `busy`=0, `key_done`=0, `error`=0
  - `spi_start`=0, `spi_data_in`=0
  - `rx_key`=0, `idx`=0 and all counters 0

## Timing
- Edge E0 samples `go`. `busy`=1 and `spi_data_in`=byte 0 are visible after E0.
- `spi_start` is high in the cycle after E0, provided `spi_busy`=0.
- `spi_done` sampled at edge Ed leads to:
  - `rx_key` updated after Ed
  - GAP_CYCLES cycles of GAP
  - `spi_start` for the next byte in cycle Ed+1+GAP_CYCLES
- Per-byte sequencer overhead is 1 (START) + GAP_CYCLES cycles, plus the master's transfer time.
- Last-byte `spi_done` at edge Ed gives `key_done` high during cycle Ed+1, then `busy` low after Ed+2.
- `busy` is high from the cycle after `go` acceptance through the DONE cycle inclusive.

## Test plan
- Reset, then `go` with `key_in`=2b7e151628aed2a6abf7158809cf4f3c and a slave echo model → 16 `spi_start` pulses carrying 2b,7e,…,3c in order. Each pulse is followed by ≥2 idle cycles after `spi_done`, `key_done` pulses once, `error`=0, and `rx_key` equals the slave's returned bytes.
- Hold `spi_busy`=1 for 5 cycles on entering START → `spi_start` stays 0 for those cycles and then pulses once; no byte is skipped or duplicated.
- Suppress `spi_done` on byte 3 → after TIMEOUT_CYCLES cycles `error`=1 and `key_done` pulses, bytes 0–2 of `rx_key` are valid, bytes 3–15 are 0, and the sequencer returns to IDLE.
- Assert `abort` in the same cycle as `spi_done` on byte 7 → byte 7 is not captured, `error`=1, and `key_done` pulses the next cycle. A subsequent `go` clears `error` and completes cleanly.
- Drop `reset` to 0 during WAIT of byte 10 → all outputs are 0 immediately (asynchronously). After release, `go` restarts from byte 0.
- Pulse `go` while `busy`=1 → ignored: the key is not re-latched and the transfer byte count stays at 16.
